// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder sequencer.
// Slice width is fixed by the 2-bit adder cell.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int SLICE_W = 2;

   function automatic int ndig(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/ready/done bundle between switch logic and the serial adder.
// Optional sub input when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output start, op_a, op_b, cin,
      input  ready, busy, done, sum, cout
   );

   modport slave (
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  start, op_a, op_b, cin,
      output ready, busy, done, sum, cout
   );

endinterface

// File: rtl/serial_adder_ctrl_adder.sv
// 2-bit ripple adder slice: {cout, s} = a + b + cin.
// Combinational; reused unchanged by the serial sequencer.
module adder2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] s,
   output logic       cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Digit-serial WIDTH-bit adder: one 2-bit digit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub (a - b) request input.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   serial_adder_ctrl_if.slave bus
);

   localparam int NDIG = ndig(WIDTH);
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH must be even and >= 2");
   end

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0] sum_r;
   logic [CW-1:0]    cnt;
   logic             carry_r;
   logic             cout_r;
   logic             ready_r;
   logic             busy_r;
   logic             done_r;
   logic [1:0]       s;
   logic             co;
   logic [WIDTH-1:0] b_ld;
   logic             c_ld;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtract as a + ~b + 1; the external carry-in is ignored then.
   assign b_ld = bus.sub ? ~bus.op_b : bus.op_b;
   assign c_ld = bus.sub ? 1'b1 : bus.cin;
`else
   assign b_ld = bus.op_b;
   assign c_ld = bus.cin;
`endif

   adder2 u_slice (
      .a    (a_sh[1:0]),
      .b    (b_sh[1:0]),
      .cin  (carry_r),
      .s    (s),
      .cout (co)
   );

   always_comb begin
      acc_nx = acc >> SLICE_W;
      acc_nx[WIDTH-1 -: SLICE_W] = s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         acc     <= '0;
         sum_r   <= '0;
         cnt     <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh    <= bus.op_a;
                  b_sh    <= b_ld;
                  carry_r <= c_ld;
                  cnt     <= '0;
                  state   <= RUN;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> SLICE_W;
               b_sh    <= b_sh >> SLICE_W;
               acc     <= acc_nx;
               carry_r <= co;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum_r  <= acc_nx;
                  cout_r <= co;
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               ready_r <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state   <= IDLE;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready = ready_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.sum   = sum_r;
   assign bus.cout  = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8).
// Covers SERIAL_ADDER_SUB_EN vectors when that macro is defined.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(8)) sif ();

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif.slave)
   );

   int vectors  = 0;
   int errors   = 0;
   int done_cnt = 0;
   logic [8:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse pops one expected {cout, sum}.
   initial begin : monitor
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && sif.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sum", {24'd0, sif.sum}, {24'd0, e[7:0]});
               chk("cout", {31'd0, sif.cout}, {31'd0, e[8]});
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (sif.ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || sif.ready !== 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   // Returns at the negedge just after the accepting edge.
   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [8:0] e,
                        input bit push = 1'b1);
      wait_ready();
      sif.op_a  = a;
      sif.op_b  = b;
      sif.cin   = c;
      sif.start = 1'b1;
      if (push) exp_q.push_back(e);
      @(negedge clk);
      sif.start = 1'b0;
   endtask

   initial begin : timeout
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin : main
      int d0;
      int last;
      bit stable;
      int n;

      sif.start = 1'b0;
      sif.op_a  = '0;
      sif.op_b  = '0;
      sif.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sif.sub   = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, sif.ready}, 32'd1);
      chk("rst_busy", {31'd0, sif.busy}, 32'd0);
      chk("rst_done", {31'd0, sif.done}, 32'd0);
      chk("rst_sum", {24'd0, sif.sum}, 32'd0);
      chk("rst_cout", {31'd0, sif.cout}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: latency and handshake timing
      issue(8'h5A, 8'h3C, 1'b0, 9'h096);
      chk("t1_ready_low", {31'd0, sif.ready}, 32'd0);
      chk("t1_busy_1", {31'd0, sif.busy}, 32'd1);
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         chk("t1_busy", {31'd0, sif.busy}, 32'd1);
      end
      @(negedge clk);
      chk("t1_done_5th", {31'd0, sif.done}, 32'd1);
      chk("t1_busy_off", {31'd0, sif.busy}, 32'd0);
      @(negedge clk);
      chk("t1_ready_back", {31'd0, sif.ready}, 32'd1);
      wait_idle();

      // 2: carry ripple and carry-in
      issue(8'hFF, 8'h01, 1'b0, 9'h100);
      issue(8'h7F, 8'h00, 1'b1, 9'h080);
      wait_idle();

      // 3: start ignored in RUN and DONE, operand changes ignored
      d0 = done_cnt;
      issue(8'h11, 8'h22, 1'b0, 9'h033);
      sif.op_a  = 8'hFF;
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      n = 0;
      while (sif.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("t3_done_timeout", 32'd0, 32'd1);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      repeat (10) @(negedge clk);
      chk("t3_one_done", done_cnt - d0, 32'd1);
      chk("t3_idle", {31'd0, sif.ready}, 32'd1);

      // 4: reset mid-RUN aborts immediately
      d0 = done_cnt;
      issue(8'hAA, 8'h55, 1'b0, 9'h0FF, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t4_sum", {24'd0, sif.sum}, 32'd0);
      chk("t4_cout", {31'd0, sif.cout}, 32'd0);
      chk("t4_ready", {31'd0, sif.ready}, 32'd1);
      chk("t4_busy", {31'd0, sif.busy}, 32'd0);
      chk("t4_done", {31'd0, sif.done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("t4_no_done", done_cnt - d0, 32'd0);
      issue(8'h01, 8'h01, 1'b0, 9'h002);
      wait_idle();

      // 5: start held high -> back-to-back, period 6
      wait_ready();
      d0 = done_cnt;
      last = -1;
      stable = 1'b1;
      sif.op_a = 8'h80;
      sif.op_b = 8'h80;
      sif.cin  = 1'b0;
      repeat (4) exp_q.push_back(9'h100);
      for (int i = 0; i <= 30; i++) begin
         sif.start = (i < 20);
         if (sif.done === 1'b1) begin
            if (last >= 0) chk("t5_gap", i - last, 32'd6);
            last = i;
         end
         if (last >= 0 && (sif.sum !== 8'h00 || sif.cout !== 1'b1))
            stable = 1'b0;
         @(negedge clk);
      end
      sif.start = 1'b0;
      chk("t5_count", done_cnt - d0, 32'd4);
      chk("t5_stable", {31'd0, stable}, 32'd1);
      wait_idle();

`ifdef SERIAL_ADDER_SUB_EN
      // 6: subtraction, cin ignored
      sif.sub = 1'b1;
      issue(8'h10, 8'h01, 1'b0, 9'h10F);
      issue(8'h01, 8'h02, 1'b0, 9'h0FF);
      wait_idle();
      sif.sub = 1'b0;
`endif

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
